fp_addsub_align: RTL and testbench
==================================

// Module: fp_addsub_align
// PURPOSE
//  Front end of the FP add/sub datapath; the normaliser is the back end. Accepts two packed IEEE-754 operands and an
//  add/sub opcode, unpacks them and aligns the smaller-exponent mantissa to the larger exponent by right shift.
//  Emits a common biased exponent plus two signed (MANT_WIDTH+3)-bit mantissas for the mantissa adder.
//  Result format: [MSB]=sign, [MSB-1]=carry headroom, [MANT_WIDTH]=hidden bit. Valid/ready handshake on both sides.
// PARAMETERS
//  EXP_WIDTH   11  exponent field width
//  MANT_WIDTH  52  fraction field width
//  DATA_WIDTH  64  packed operand width (1+EXP_WIDTH+MANT_WIDTH)
// PORTS
//  in_clk           in   1             clock; all logic on rising edge
//  in_rst           in   1             synchronous, active-high reset
//  in_valid         in   1             upstream operands valid
//  out_ready        out  1             block can accept operands
//  in_A, in_B       in   DATA_WIDTH    packed operands
//  in_op            in   1             0 = A+B, 1 = A-B
//  out_valid        out  1             aligned result valid
//  in_ready         in   1             downstream accepts result
//  out_Exp          out  EXP_WIDTH     larger biased exponent
//  out_MantA/B      out  MANT_WIDTH+3  aligned two's-complement mantissas of A and B (identity kept, never swapped)
//  out_flag_special out  1             either operand has exponent all-ones (Inf/NaN)
// BEHAVIOUR
//  - Reset: state IDLE; out_valid=0; out_Exp, out_MantA/B, out_flag_special = 0. out_ready=0 while in_rst=1.
//  - out_ready = (state==IDLE) & ~in_rst. Accept on in_valid & out_ready: register in_A, in_B, in_op.
//  - FSM IDLE->COMPARE->SHIFT->CONVERT->HOLD->IDLE.
//  - COMPARE: hidden bit = (exp!=0). Effective exp = 1 when field is 0 (denormal). d = |eA-eB|, d computed in
//    EXP_WIDTH+1 bits. Load shift counter with d. The operand with the smaller exponent is the shift target.
//  - COMPARE exits: d=0 -> CONVERT (SHIFT skipped). d>MANT_WIDTH+2 -> target mantissa forced 0, -> CONVERT.
//    Special operand -> both mantissas 0, out_flag_special=1, -> CONVERT.
//  - SHIFT: target >>1 per cycle, zero fill, counter-1. Exit to CONVERT when the counter reaches 0.
//    Shifted-out bits are discarded (truncate, no sticky).
//  - CONVERT: effective sign of B = sB^in_op. Negative operands are two's-negated in MANT_WIDTH+3 bits.
//    Register all outputs; out_valid=1 the next cycle.
//  - HOLD: out_valid=1 and outputs stable until in_ready=1. On that edge -> IDLE, out_valid=0.
//    in_valid is ignored outside IDLE.
//  - Latency (accept edge to out_valid): 3+d cycles; 3 when SHIFT is skipped.
//  - in_rst in any state, including mid-SHIFT: abort with no out_valid pulse; return to IDLE.
// CONFIGURATION
//  - ALIGN_BARREL_SHIFT_EN defined: SHIFT state removed. The COMPARE->CONVERT path applies a single-cycle barrel
//    shift by d. Latency is fixed at 3 cycles.
//  - Undefined: iterative 1-bit/cycle shifter as above; latency 3+d, max d = MANT_WIDTH+2.
// STRUCTURE
//  - Package fp_addsub_pkg: EXP_WIDTH/MANT_WIDTH/DATA_WIDTH constants; sign/exp/frac slice positions; FSM state
//    encoding; EXP_ALL_ONES constant. The normaliser shares this package.
//  - One sub-module fp_addsub_unpack (combinational, instantiated twice): splits an operand into sign, effective
//    exponent, hidden+fraction mantissa and special flag.
// TESTING
//  1. A=0x3FF0000000000000, B=0x3FF0000000000000, op=0 -> Exp=0x3FF, MantA=MantB=0x10000000000000, latency 3.
//  2. A=0x3FF0000000000000, B=0x3FE0000000000000, op=1 -> Exp=0x3FF, MantA=0x10000000000000,
//     MantB=0x78000000000000; latency 4 (3 with BARREL).
//  3. A=0x3FF0000000000000, B=0x3C30000000000000 (d=60) -> MantB=0, latency 3.
//  4. in_ready=0 for 5 cycles after out_valid -> out_valid and outputs stable, out_ready=0,
//     in_valid pulses ignored; completes on in_ready=1.
//  5. d=40 transfer, in_rst=1 for one cycle at 10th SHIFT cycle -> out_valid never rises, out_ready=1 next cycle.
//  6. A=0x7FF0000000000000 (+Inf), B=1.0 -> out_flag_special=1, MantA=MantB=0, latency 3.

Source files
------------

// File: rtl/fp_addsub_pkg.sv
// Shared constants, field positions and types for the FP add/sub datapath (aligner and normaliser).
package fp_addsub_pkg;

    localparam int EXP_WIDTH  = 11;
    localparam int MANT_WIDTH = 52;
    localparam int DATA_WIDTH = 1 + EXP_WIDTH + MANT_WIDTH;

    // Aligned mantissa: sign, carry headroom, hidden bit, fraction.
    localparam int AL_WIDTH = MANT_WIDTH + 3;

    localparam int SIGN_POS = DATA_WIDTH - 1;
    localparam int EXP_MSB  = DATA_WIDTH - 2;
    localparam int EXP_LSB  = MANT_WIDTH;
    localparam int FRAC_MSB = MANT_WIDTH - 1;

    localparam logic [EXP_WIDTH-1:0] EXP_ALL_ONES = '1;
    localparam logic [EXP_WIDTH:0]   MAX_SHIFT    = (EXP_WIDTH + 1)'(MANT_WIDTH + 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_SHIFT,
        ST_CONVERT,
        ST_HOLD
    } state_t;

    typedef struct packed {
        logic                  sign;
        logic [EXP_WIDTH-1:0]  exp;
        logic [MANT_WIDTH:0]   mant;
        logic                  special;
    } unpacked_t;

    function automatic logic [AL_WIDTH-1:0] apply_sign(input logic neg, input logic [AL_WIDTH-1:0] mag);
        return neg ? -mag : mag;
    endfunction

endpackage

// File: rtl/fp_addsub_unpack.sv
// Splits a packed IEEE-754 operand into sign, effective exponent, hidden+fraction mantissa and Inf/NaN flag.
module fp_addsub_unpack
    import fp_addsub_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] raw,
    output unpacked_t             fields
);

    logic [EXP_WIDTH-1:0] exp_field;
    logic                 hidden;

    always_comb begin
        exp_field      = raw[EXP_MSB:EXP_LSB];
        hidden         = |exp_field;
        fields.sign    = raw[SIGN_POS];
        // Denormals share the exponent of the smallest normal, just without the hidden bit.
        fields.exp     = hidden ? exp_field : EXP_WIDTH'(1);
        fields.mant    = {hidden, raw[FRAC_MSB:0]};
        fields.special = (exp_field == EXP_ALL_ONES);
    end

endmodule

// File: rtl/fp_addsub_align.sv
// FP add/sub front end: unpack, exponent compare and right-shift alignment of the smaller operand.
// Define ALIGN_BARREL_SHIFT_EN to replace the 1-bit/cycle SHIFT loop with a single-cycle barrel shift.
module fp_addsub_align
    import fp_addsub_pkg::*;
(
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_valid,
    output logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] in_A,
    input  logic [DATA_WIDTH-1:0] in_B,
    input  logic                  in_op,
    output logic                  out_valid,
    input  logic                  in_ready,
    output logic [EXP_WIDTH-1:0]  out_Exp,
    output logic [AL_WIDTH-1:0]   out_MantA,
    output logic [AL_WIDTH-1:0]   out_MantB,
    output logic                  out_flag_special
);

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic                  op_q;
    unpacked_t             ua, ub;
    logic                  accept, b_is_target, any_special, too_far;
    logic [EXP_WIDTH:0]    diff;
    logic [EXP_WIDTH-1:0]  exp_max, exp_q;
    logic [AL_WIDTH-1:0]   tgt_mag, tgt_aligned, mag_a, mag_b;
    logic                  special_q;
`ifndef ALIGN_BARREL_SHIFT_EN
    logic [EXP_WIDTH:0]    shift_cnt;
    logic                  tgt_is_b_q;
    localparam logic [EXP_WIDTH:0] CNT_LAST = (EXP_WIDTH + 1)'(1);
`endif

    fp_addsub_unpack u_unpack_a (.raw(a_q), .fields(ua));
    fp_addsub_unpack u_unpack_b (.raw(b_q), .fields(ub));

    always_comb begin
        b_is_target = (ua.exp >= ub.exp);
        exp_max     = b_is_target ? ua.exp : ub.exp;
        diff        = b_is_target ? ({1'b0, ua.exp} - {1'b0, ub.exp})
                                  : ({1'b0, ub.exp} - {1'b0, ua.exp});
        any_special = ua.special | ub.special;
        too_far     = (diff > MAX_SHIFT);
        tgt_mag     = b_is_target ? {2'b00, ub.mant} : {2'b00, ua.mant};
`ifdef ALIGN_BARREL_SHIFT_EN
        tgt_aligned = too_far ? '0 : (tgt_mag >> diff);
`else
        tgt_aligned = too_far ? '0 : tgt_mag;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge in_clk) begin
        if (in_rst) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept) state_nxt = ST_COMPARE;
`ifdef ALIGN_BARREL_SHIFT_EN
            ST_COMPARE: state_nxt = ST_CONVERT;
`else
            ST_COMPARE: state_nxt = (any_special || too_far || diff == '0) ? ST_CONVERT : ST_SHIFT;
            ST_SHIFT:   if (shift_cnt == CNT_LAST) state_nxt = ST_CONVERT;
`endif
            ST_CONVERT: state_nxt = ST_HOLD;
            ST_HOLD:    if (in_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        out_ready = (state == ST_IDLE) && !in_rst;
        out_valid = (state == ST_HOLD);
        accept    = in_valid && out_ready;
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            a_q              <= '0;
            b_q              <= '0;
            op_q             <= 1'b0;
            exp_q            <= '0;
            mag_a            <= '0;
            mag_b            <= '0;
            special_q        <= 1'b0;
            out_Exp          <= '0;
            out_MantA        <= '0;
            out_MantB        <= '0;
            out_flag_special <= 1'b0;
`ifndef ALIGN_BARREL_SHIFT_EN
            shift_cnt        <= '0;
            tgt_is_b_q       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    a_q  <= in_A;
                    b_q  <= in_B;
                    op_q <= in_op;
                end
                ST_COMPARE: begin
                    exp_q     <= exp_max;
                    special_q <= any_special;
`ifndef ALIGN_BARREL_SHIFT_EN
                    shift_cnt  <= diff;
                    tgt_is_b_q <= b_is_target;
`endif
                    if (any_special) begin
                        mag_a <= '0;
                        mag_b <= '0;
                    end else if (b_is_target) begin
                        mag_a <= {2'b00, ua.mant};
                        mag_b <= tgt_aligned;
                    end else begin
                        mag_a <= tgt_aligned;
                        mag_b <= {2'b00, ub.mant};
                    end
                end
`ifndef ALIGN_BARREL_SHIFT_EN
                ST_SHIFT: begin
                    // Truncating shift: bits falling off the LSB are dropped, no sticky.
                    shift_cnt <= shift_cnt - CNT_LAST;
                    if (tgt_is_b_q) mag_b <= mag_b >> 1;
                    else            mag_a <= mag_a >> 1;
                end
`endif
                ST_CONVERT: begin
                    out_Exp          <= exp_q;
                    out_MantA        <= apply_sign(ua.sign, mag_a);
                    out_MantB        <= apply_sign(ub.sign ^ op_q, mag_b);
                    out_flag_special <= special_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_align.sv
// Directed self-checking bench for fp_addsub_align; expected latencies follow ALIGN_BARREL_SHIFT_EN.
module tb_fp_addsub_align;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_A, in_B;
    logic        in_op;
    logic        out_valid;
    logic        in_ready;
    logic [10:0] out_Exp;
    logic [54:0] out_MantA, out_MantB;
    logic        out_flag_special;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ALIGN_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    localparam logic [63:0] ONE  = 64'h3FF0000000000000;
    localparam logic [63:0] HALF = 64'h3FE0000000000000;

    fp_addsub_align dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid), .out_ready(out_ready),
        .in_A(in_A), .in_B(in_B), .in_op(in_op), .out_valid(out_valid), .in_ready(in_ready),
        .out_Exp(out_Exp), .out_MantA(out_MantA), .out_MantB(out_MantB),
        .out_flag_special(out_flag_special)
    );

    always #5 in_clk = ~in_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input int d);
        if (BARREL || d == 0 || d > 54) return 3;
        return 3 + d;
    endfunction

    // Called at #1 after a rising edge; returns at #1 after the accept edge.
    task automatic send(input string tag, input logic [63:0] a, input logic [63:0] b, input logic op);
        in_A = a; in_B = b; in_op = op; in_valid = 1'b1;
        check({tag, "_ready"}, out_ready, 1);
        @(posedge in_clk); #1;
        in_valid = 1'b0;
    endtask

    // Latency = rising edges from the accept edge to the edge that transfers the result.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge in_clk); #1;
            lat++;
        end
        lat = lat + 1;
    endtask

    task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b, input logic op,
                       input int d, input logic [10:0] e, input logic [54:0] ma, input logic [54:0] mb,
                       input logic sp);
        int lat;
        send(tag, a, b, op);
        wait_valid(lat);
        check({tag, "_lat"},   lat,              exp_lat(d));
        check({tag, "_valid"}, out_valid,        1);
        check({tag, "_exp"},   out_Exp,          e);
        check({tag, "_manta"}, out_MantA,        ma);
        check({tag, "_mantb"}, out_MantB,        mb);
        check({tag, "_spec"},  out_flag_special, sp);
        @(posedge in_clk); #1;
        check({tag, "_done"},  out_valid,        0);
    endtask

    initial begin
        int lat;
        bit seen_valid;
        logic [54:0] held_b;

        in_rst = 1'b1; in_valid = 1'b0; in_ready = 1'b1;
        in_A = '0; in_B = '0; in_op = 1'b0;
        repeat (3) @(posedge in_clk);
        #1;
        check("rst_ready", out_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_exp",   out_Exp,   0);
        check("rst_manta", out_MantA, 0);
        check("rst_mantb", out_MantB, 0);
        check("rst_spec",  out_flag_special, 0);
        in_rst = 1'b0;
        #1;
        check("rst_release_ready", out_ready, 1);
        @(posedge in_clk); #1;

        run("add_equal", ONE, ONE, 1'b0, 0, 11'h3FF, 55'h10000000000000, 55'h10000000000000, 1'b0);
        run("sub_half",  ONE, HALF, 1'b1, 1, 11'h3FF, 55'h10000000000000, 55'h78000000000000, 1'b0);
        run("far_d60",   ONE, 64'h3C30000000000000, 1'b0, 60, 11'h3FF, 55'h10000000000000, 55'h0, 1'b0);
        run("neg_a",     64'hC000000000000000, ONE, 1'b0, 1, 11'h400, 55'h70000000000000, 55'h08000000000000, 1'b0);
        run("a_target",  HALF, 64'hBFF0000000000000, 1'b1, 1, 11'h3FF, 55'h08000000000000, 55'h10000000000000, 1'b0);
        run("denorm",    64'h0000000000000001, 64'h0010000000000000, 1'b1, 0, 11'h001, 55'h1, 55'h70000000000000, 1'b0);
        run("trunc_d52", ONE, 64'h3CB8000000000000, 1'b0, 52, 11'h3FF, 55'h10000000000000, 55'h1, 1'b0);
        run("edge_d55",  ONE, 64'h3C88000000000000, 1'b0, 55, 11'h3FF, 55'h10000000000000, 55'h0, 1'b0);
        run("special",   64'h7FF0000000000000, ONE, 1'b0, 0, 11'h7FF, 55'h0, 55'h0, 1'b1);

        // Back-pressure: result must hold while in_ready is low and new operands are ignored.
        in_ready = 1'b0;
        send("hold", ONE, HALF, 1'b0);
        wait_valid(lat);
        check("hold_lat",   lat,       exp_lat(1));
        check("hold_mantb", out_MantB, 55'h08000000000000);
        held_b = out_MantB;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_A = 64'h4000000000000000 + 64'(i);
            in_B = 64'h3000000000000000;
            @(posedge in_clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_ready", out_ready, 0);
            check("hold_stable_b", out_MantB, held_b);
            check("hold_stable_e", out_Exp, 11'h3FF);
        end
        in_valid = 1'b0;
        in_ready = 1'b1;
        @(posedge in_clk); #1;
        check("hold_release", out_valid, 0);
        check("hold_idle",    out_ready, 1);
        seen_valid = 1'b0;
        repeat (10) begin
            @(posedge in_clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("hold_no_stray", seen_valid, 0);

        // Abort mid-transfer: reset inside the SHIFT loop (or during CONVERT for the barrel build).
        send("abort", ONE, 64'h3D70000000000000, 1'b0);
        seen_valid = 1'b0;
        repeat (BARREL ? 1 : 10) begin
            @(posedge in_clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        in_rst = 1'b1;
        #1;
        check("abort_rst_ready", out_ready, 0);
        @(posedge in_clk); #1;
        in_rst = 1'b0;
        #1;
        check("abort_ready", out_ready, 1);
        check("abort_manta_clr", out_MantA, 0);
        repeat (70) begin
            @(posedge in_clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("abort_no_valid", seen_valid, 0);

        run("after_abort", ONE, ONE, 1'b0, 0, 11'h3FF, 55'h10000000000000, 55'h10000000000000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
